// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential signed divider
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE_S
   } state_t;

   localparam int DEF_WIDTH = 32;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// rtl/seq_signed_divider_if.sv - request/result bundle between a requester and the divider
interface seq_signed_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             START;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             DIV0;
   logic             OVF;

   modport master (
      output START, X, Y,
      input  BUSY, DONE, Q, R, DIV0, OVF
   );

   modport slave (
      input  START, X, Y,
      output BUSY, DONE, Q, R, DIV0, OVF
   );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration on unsigned magnitudes
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] dq,
   input  logic [WIDTH-1:0] ym,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] dq_nxt
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < ym <= 2^(WIDTH-1), so the extra bit only ever carries the borrow
   assign shifted = {rem, dq[WIDTH-1]};
   assign trial   = shifted - {1'b0, ym};
   assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign dq_nxt  = {dq[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - iterative signed divider, truncating quotient and
// dividend-signed remainder, fixed WIDTH+2 cycle latency
module seq_signed_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic                 CLK,
   input logic                 RESET,
   seq_signed_divider_if.slave bus
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, dq, ym;
   logic [WIDTH-1:0] rem_nxt, dq_nxt;
   logic [WIDTH-1:0] x_cap;
   logic             sign_x, sign_y, y_zero, ovf_case;
   logic [WIDTH-1:0] q_reg, r_reg;
   logic             div0_reg, ovf_reg;
   logic             busy, done, load, step, fix;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      fix       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.START) begin
               load      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == '0) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            fix       = 1'b1;
            state_nxt = DONE_S;
         end
         DONE_S: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .dq      (dq),
      .ym      (ym),
      .rem_nxt (rem_nxt),
      .dq_nxt  (dq_nxt)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt      <= '0;
         rem      <= '0;
         dq       <= '0;
         ym       <= '0;
         x_cap    <= '0;
         sign_x   <= 1'b0;
         sign_y   <= 1'b0;
         y_zero   <= 1'b0;
         ovf_case <= 1'b0;
         q_reg    <= '0;
         r_reg    <= '0;
         div0_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else begin
         if (load) begin
            // dq starts as |X| and is shifted out into rem while quotient bits shift in
            sign_x   <= bus.X[WIDTH-1];
            sign_y   <= bus.Y[WIDTH-1];
            dq       <= bus.X[WIDTH-1] ? -bus.X : bus.X;
            ym       <= bus.Y[WIDTH-1] ? -bus.Y : bus.Y;
            rem      <= '0;
            cnt      <= CW'(WIDTH - 1);
            x_cap    <= bus.X;
            y_zero   <= (bus.Y == '0);
            ovf_case <= (bus.X == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.Y == '1);
         end
         if (step) begin
            rem <= rem_nxt;
            dq  <= dq_nxt;
            cnt <= cnt - 1'b1;
         end
         if (fix) begin
            div0_reg <= y_zero;
            ovf_reg  <= ovf_case;
            if (y_zero) begin
               q_reg <= '1;
               r_reg <= x_cap;
            end else if (ovf_case) begin
               q_reg <= {1'b1, {(WIDTH-1){1'b0}}};
               r_reg <= '0;
            end else begin
               q_reg <= (sign_x ^ sign_y) ? -dq : dq;
               r_reg <= sign_x ? -rem : rem;
            end
         end
      end
   end

   assign bus.BUSY = busy;
   assign bus.DONE = done;
   assign bus.Q    = q_reg;
   assign bus.R    = r_reg;
   assign bus.DIV0 = div0_reg;
   assign bus.OVF  = ovf_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed self-checking bench for seq_signed_divider
module tb_seq_signed_divider;
   import div_pkg::*;

   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 2;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;

   seq_signed_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_signed_divider #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                    tag, $signed(obs), obs, $signed(exp), exp);
   endtask

   // called at a negedge; request is sampled on the following posedge
   task automatic start_op(input int x, input int y);
      bus.START = 1'b1;
      bus.X     = x;
      bus.Y     = y;
      @(posedge CLK);
      #1;
      bus.START = 1'b0;
      bus.X     = $urandom;
      bus.Y     = $urandom;
   endtask

   // returns at the negedge of the IDLE cycle following DONE
   task automatic wait_done(input int c0, output int lat);
      int n    = c0;
      int berr = 0;
      bit got  = 1'b0;
      while (!got && n < 200) begin
         @(negedge CLK);
         n++;
         if (bus.DONE) begin
            got = 1'b1;
            if (bus.BUSY) berr++;
         end else if (!bus.BUSY) begin
            berr++;
         end
      end
      lat = got ? n : -1;
      chk("busy_window", berr, 0);
      if (got) begin
         @(negedge CLK);
         chk("done_single", {31'b0, bus.DONE}, 0);
      end
   endtask

   task automatic check_res(input string tag, input int lat, input int q, input int r,
                            input bit d0, input bit ov);
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_q"}, bus.Q, q);
      chk({tag, "_r"}, bus.R, r);
      chk({tag, "_div0"}, {31'b0, bus.DIV0}, {31'b0, d0});
      chk({tag, "_ovf"}, {31'b0, bus.OVF}, {31'b0, ov});
   endtask

   task automatic run_op(input string tag, input int x, input int y, input int q,
                         input int r, input bit d0, input bit ov);
      int lat;
      start_op(x, y);
      wait_done(0, lat);
      check_res(tag, lat, q, r, d0, ov);
   endtask

   initial begin
      int lat;
      int dc;
      bus.START = 1'b0;
      bus.X     = '0;
      bus.Y     = '0;
      #1;
      chk("rst_busy", {31'b0, bus.BUSY}, 0);
      chk("rst_done", {31'b0, bus.DONE}, 0);
      chk("rst_q", bus.Q, 0);
      chk("rst_r", bus.R, 0);
      chk("rst_div0", {31'b0, bus.DIV0}, 0);
      chk("rst_ovf", {31'b0, bus.OVF}, 0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      run_op("p100_7", 100, 7, 14, 2, 1'b0, 1'b0);
      run_op("n100_7", -100, 7, -14, -2, 1'b0, 1'b0);
      run_op("p100_n7", 100, -7, -14, 2, 1'b0, 1'b0);
      run_op("n81_n55", -81, -55, 1, -26, 1'b0, 1'b0);
      run_op("n12340_123", -12340, 123, -100, -40, 1'b0, 1'b0);
      run_op("div0", 1577, 0, -1, 1577, 1'b1, 1'b0);
      run_op("zero_n300", 0, -300, 0, 0, 1'b0, 1'b0);
      run_op("ovf", 32'h8000_0000, -1, 32'h8000_0000, 0, 1'b0, 1'b1);
      run_op("min_2", 32'h8000_0000, 2, -1073741824, 0, 1'b0, 1'b0);

      // a request while busy must neither restart nor recapture operands
      start_op(100, 7);
      repeat (9) @(negedge CLK);
      bus.START = 1'b1;
      bus.X     = 9;
      bus.Y     = 3;
      @(posedge CLK);
      #1;
      bus.START = 1'b0;
      wait_done(9, lat);
      check_res("ignored", lat, 14, 2, 1'b0, 1'b0);
      run_op("p9_3", 9, 3, 3, 0, 1'b0, 1'b0);

      // asynchronous abort mid-calculation
      start_op(100, 7);
      repeat (14) @(negedge CLK);
      #2;
      RESET = 1'b0;
      #1;
      chk("abort_busy", {31'b0, bus.BUSY}, 0);
      chk("abort_done", {31'b0, bus.DONE}, 0);
      chk("abort_q", bus.Q, 0);
      chk("abort_r", bus.R, 0);
      @(negedge CLK);
      RESET = 1'b1;
      dc = 0;
      repeat (40) begin
         @(negedge CLK);
         if (bus.DONE) dc++;
      end
      chk("abort_no_done", dc, 0);
      run_op("p50_6", 50, 6, 8, 2, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Iterative signed integer divider; the inverse operation of the Booth multiplier, sitting beside it in the arithmetic datapath.
- Accepts dividend X and divisor Y on a START pulse and returns quotient Q and remainder R after a fixed latency.
- Uses shift-subtract (restoring) on magnitudes, then applies sign correction.
- Results match Verilog signed `/` and `%`: truncation toward zero, remainder takes the dividend's sign.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)

Ports:
CLK    input   1      clock, rising edge
RESET  input   1      asynchronous, active-low reset (0 = reset asserted)
START  input   1      request; sampled only when BUSY=0
X      input   WIDTH  signed dividend, captured with START
Y      input   WIDTH  signed divisor, captured with START
BUSY   output  1      high from the cycle after START is accepted until DONE
DONE   output  1      single-cycle pulse; Q/R/flags valid from this cycle on
Q      output  WIDTH  signed quotient
R      output  WIDTH  signed remainder
DIV0   output  1      divisor was zero (valid with DONE, held)
OVF    output  1      X = -2^(WIDTH-1) and Y = -1 (valid with DONE, held)

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; BUSY=0, DONE=0, Q=0, R=0, DIV0=0, OVF=0; internal registers cleared. Reset mid-operation aborts with no DONE.
- States:
  - IDLE: START=1 captures X and Y, records sign_x and sign_y, loads |X| and |Y| as unsigned WIDTH-bit values, clears the partial remainder, sets counter=WIDTH-1, and moves to CALC. |(-2^(WIDTH-1))| = 2^(WIDTH-1) fits unsigned.
  - CALC: one quotient bit per cycle. Shift {rem, dq} left by 1; trial = rem - |Y| at WIDTH+1 bits. If trial is non-negative, rem = trial and the new q bit is 1; otherwise 0. Counter decrements; at 0 go to FIX. CALC lasts exactly WIDTH cycles.
  - FIX: compute outputs.
    - Q = sign_x^sign_y ? -qmag : qmag
    - R = sign_x ? -rem : rem
    - If Y==0: Q = all ones (-1), R = X, DIV0=1.
    - If overflow case: Q = -2^(WIDTH-1), R = 0, OVF=1. The unsigned path produces this naturally; the flag is set explicitly.
    - Go to DONE_S.
  - DONE_S: DONE=1 for one cycle, BUSY=0 in this cycle, then return to IDLE.
- Timing and output holding:
  - Latency is fixed at WIDTH+2 cycles from the START-accept edge to DONE high, for every case including DIV0 and OVF.
  - BUSY=1 during CALC and FIX.
  - Q, R, DIV0 and OVF hold their values until the next FIX. They are not cleared on START.
- Handshake:
  - START while BUSY=1 (CALC/FIX) is ignored, and inputs are not recaptured.
  - START coincident with DONE_S is also ignored. A new operation may start from IDLE, i.e. one cycle after DONE.
  - X and Y may change freely after the accept edge.
- Width rules: the remainder path is WIDTH+1 bits to hold the subtract borrow. Magnitudes are unsigned WIDTH bits. Negation is two's complement mod 2^WIDTH.

Decomposition:
- Package div_pkg holds:
  - state enum {IDLE, CALC, FIX, DONE_S}
  - default WIDTH constant
  - function cnt_w(WIDTH) = $clog2(WIDTH)
- One natural combinational sub-module, div_step. Inputs: rem, dq, |Y|. Outputs: next rem, next dq with the quotient bit inserted. It is instantiated once in CALC.

Test Plan:
- X=100, Y=7, START for 1 cycle → DONE exactly 34 cycles after accept; Q=14, R=2, DIV0=0, OVF=0; BUSY high cycles 1..33.
- Sign matrix, back-to-back with START the cycle after each DONE:
  - -100/7 → Q=-14, R=-2
  - 100/-7 → Q=-14, R=2
  - -81/-55 → Q=1, R=-26
  - -12340/123 → Q=-100, R=-40
- X=1577, Y=0 → Q=-1 (0xFFFFFFFF), R=1577, DIV0=1, latency still 34. X=0, Y=-300 → Q=0, R=0.
- X=-2147483648, Y=-1 → Q=-2147483648, R=0, OVF=1. X=-2147483648, Y=2 → Q=-1073741824, R=0, OVF=0.
- Start 100/7; pulse START with X=9, Y=3 at cycle 10 (busy) → ignored, result Q=14, R=2. Then 9/3 → Q=3, R=0.
- Start 100/7; drive RESET=0 at cycle 15 → all outputs 0 immediately (asynchronous), no DONE. Release, start 50/6 → Q=8, R=2 after 34 cycles.
